pc_sequencer: RTL and testbench
===============================

# pc_sequencer

Multicycle program-counter sequencer for the MIPS core on the Basys3 board. It owns the architectural PC and steps each instruction through fetch, decode-wait, resolve and commit. At resolve it selects the next PC from one of five sources: sequential, taken branch, J, JAL or JR. It handshakes with instruction fetch, drives the JAL link write, and exposes per-commit pulses for the register file and debug logic.

## Interface
Parameters:
- RESET_PC, 32'd0, PC value loaded on reset (word index).

Ports:
- clk  in  1  system clock; all state changes on rising edge
- rst_n  in  1  reset, synchronous, active-low
- start  in  1  leave IDLE and begin fetching; ignored outside IDLE
- halt  in  1  request stop after the instruction currently in flight commits
- fetch_req  out  1  PC valid, fetch requested
- fetch_ready  in  1  fetch accepted; sampled only while fetch_req=1
- instr_valid  in  1  decoded fields valid; sampled only in WAIT_DEC
- path_index  in  4  decode path code: 4=branch, 5=J, 6=JAL, 8=JR, other=sequential
- addr  in  26  J/JAL target field
- imm  in  16  branch offset in words, signed
- branch_taken  in  1  branch condition result
- reg_addr  in  32  JR target (rs value)
- pc  out  32  architectural PC (word index)
- pc_update  out  1  one-cycle pulse in COMMIT
- link_we  out  1  one-cycle pulse in COMMIT when the committed instruction is JAL
- link_data  out  32  pc+1 of the JAL instruction; valid while link_we=1
- busy  out  1  high in FETCH, WAIT_DEC, RESOLVE, COMMIT
- state  out  3  IDLE=0, FETCH=1, WAIT_DEC=2, RESOLVE=3, COMMIT=4, HALTED=5
- retire_count  out  32  committed-instruction count (see Configuration)

## Operation
- IDLE: if start=1, go to FETCH; otherwise stay.
- FETCH: fetch_req=1 and pc held stable. If fetch_ready=1, go to WAIT_DEC; otherwise stay.
- WAIT_DEC: if instr_valid=1, capture path_index, addr, imm, branch_taken and reg_addr into internal registers, then go to RESOLVE. Decode inputs are ignored in all other states.
- RESOLVE: compute next_pc from the captured fields into a register, then go to COMMIT:
  - path 5 or 6: {pc[31:26], addr}
  - path 8: reg_addr
  - path 4 with branch_taken=1: pc + 1 + sign_extend(imm)
  - path 4 with branch_taken=0, or any other code: pc + 1
- COMMIT: pc <= next_pc; pc_update=1; link_we=1 only if the captured path is 6. Then go to HALTED if halt_pending, else to FETCH.
- HALTED: terminal state; exited only by reset. fetch_req=0, busy=0.
- halt_pending: set by halt=1 in any state except IDLE and HALTED; cleared on entry to HALTED and by reset. halt in IDLE is ignored.
- Arithmetic: all additions are 32-bit modulo. Wrap from 0xFFFFFFFF to 0 is legal and silent. sign_extend copies imm[15] into bits 31:16.
- link_data = captured pc + 1, computed modulo 2^32.

## Timing
- Reset (rst_n=0 at a rising edge): pc=RESET_PC, state=IDLE, fetch_req=0, pc_update=0, link_we=0, link_data=0, busy=0, halt_pending=0, retire_count=0, captured fields=0.
- Reset mid-operation: abandons the in-flight instruction; no pc_update or link_we is issued.
- Minimum instruction latency is 4 cycles (FETCH, WAIT_DEC, RESOLVE, COMMIT) when fetch_ready and instr_valid are already high. Each cycle either signal is low adds one cycle.
- pc changes only on the edge leaving COMMIT; the new value is visible in the following FETCH.
- pc_update and link_we are registered, high exactly one cycle, and never high outside COMMIT.
- halt=1 and start=1 together in IDLE: start wins; halt is ignored.
- halt=1 during COMMIT: halt_pending is set and takes effect on that same transition, so the next state is HALTED.

## Configuration
- PC_RETIRE_CNT_EN defined: retire_count increments by 1 (modulo 2^32) on every COMMIT cycle and is cleared on reset.
- PC_RETIRE_CNT_EN undefined: the counter logic is removed and retire_count is tied to 32'd0.

## Test plan
- Reset, then start, with fetch_ready and instr_valid held high and path 0 repeated 3 times -> pc goes 0→1→2→3, one pc_update every 4 cycles, retire_count=3 (macro on).
- pc=0x0000_0010, path 6, addr=0x0000_123 -> link_we=1 with link_data=0x11, then pc=0x0000_0123. Same setup with path 5 -> no link_we.
- pc=0x20, path 4, branch_taken=1, imm=16'hFFFC -> pc=0x1D. Same with branch_taken=0 -> pc=0x21.
- path 8, reg_addr=0xFFFF_FFFF, then path 0 -> pc=0xFFFF_FFFF, then wraps to 0x0000_0000.
- fetch_ready held low for 5 cycles in FETCH -> state stays 1 with fetch_req=1 and pc stable. Pulse halt during WAIT_DEC -> that instruction commits, then state=5 with busy=0.
- Assert rst_n=0 in RESOLVE -> next cycle state=0 and pc=RESET_PC, with no pc_update pulse.

Source files
------------

// File: rtl/pc_sequencer.sv
// Multicycle PC sequencer: FETCH -> WAIT_DEC -> RESOLVE -> COMMIT with five next-PC sources.
// Optional retire counter is enabled by defining PC_RETIRE_CNT_EN.
module pc_sequencer #(
    parameter logic [31:0] RESET_PC = 32'd0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        halt,
    output logic        fetch_req,
    input  logic        fetch_ready,
    input  logic        instr_valid,
    input  logic [3:0]  path_index,
    input  logic [25:0] addr,
    input  logic [15:0] imm,
    input  logic        branch_taken,
    input  logic [31:0] reg_addr,
    output logic [31:0] pc,
    output logic        pc_update,
    output logic        link_we,
    output logic [31:0] link_data,
    output logic        busy,
    output logic [2:0]  state,
    output logic [31:0] retire_count
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_FETCH    = 3'd1;
    localparam logic [2:0] S_WAIT_DEC = 3'd2;
    localparam logic [2:0] S_RESOLVE  = 3'd3;
    localparam logic [2:0] S_COMMIT   = 3'd4;
    localparam logic [2:0] S_HALTED   = 3'd5;

    localparam logic [3:0] PATH_BRANCH = 4'd4;
    localparam logic [3:0] PATH_J      = 4'd5;
    localparam logic [3:0] PATH_JAL    = 4'd6;
    localparam logic [3:0] PATH_JR     = 4'd8;

    logic [2:0]  r_state;
    logic [31:0] r_pc;
    logic [31:0] r_nextPc;
    logic        r_pcUpdate;
    logic        r_linkWe;
    logic [31:0] r_linkData;
    logic        r_haltPending;
    logic [3:0]  r_path;
    logic [25:0] r_addr;
    logic [15:0] r_imm;
    logic        r_taken;
    logic [31:0] r_regAddr;

    logic [31:0] w_pcPlus1;
    logic [31:0] w_branchTarget;
    logic        w_haltReq;

    assign w_pcPlus1      = r_pc + 32'd1;
    assign w_branchTarget = w_pcPlus1 + {{16{r_imm[15]}}, r_imm};
    // A halt arriving in the COMMIT cycle itself must still steer that transition.
    assign w_haltReq      = r_haltPending |
                            (halt & (r_state != S_IDLE) & (r_state != S_HALTED));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_pc          <= RESET_PC;
            r_nextPc      <= 32'd0;
            r_pcUpdate    <= 1'b0;
            r_linkWe      <= 1'b0;
            r_linkData    <= 32'd0;
            r_haltPending <= 1'b0;
            r_path        <= 4'd0;
            r_addr        <= 26'd0;
            r_imm         <= 16'd0;
            r_taken       <= 1'b0;
            r_regAddr     <= 32'd0;
        end else begin
            r_haltPending <= w_haltReq;
            r_pcUpdate    <= (r_state == S_RESOLVE);
            r_linkWe      <= (r_state == S_RESOLVE) && (r_path == PATH_JAL);
            case (r_state)
                S_IDLE: begin
                    if (start) r_state <= S_FETCH;
                end
                S_FETCH: begin
                    if (fetch_ready) r_state <= S_WAIT_DEC;
                end
                S_WAIT_DEC: begin
                    if (instr_valid) begin
                        r_path    <= path_index;
                        r_addr    <= addr;
                        r_imm     <= imm;
                        r_taken   <= branch_taken;
                        r_regAddr <= reg_addr;
                        r_state   <= S_RESOLVE;
                    end
                end
                S_RESOLVE: begin
                    case (r_path)
                        PATH_J, PATH_JAL: r_nextPc <= {r_pc[31:26], r_addr};
                        PATH_JR:          r_nextPc <= r_regAddr;
                        PATH_BRANCH:      r_nextPc <= r_taken ? w_branchTarget : w_pcPlus1;
                        default:          r_nextPc <= w_pcPlus1;
                    endcase
                    if (r_path == PATH_JAL) r_linkData <= w_pcPlus1;
                    r_state <= S_COMMIT;
                end
                S_COMMIT: begin
                    r_pc <= r_nextPc;
                    if (w_haltReq) begin
                        r_state       <= S_HALTED;
                        r_haltPending <= 1'b0;
                    end else begin
                        r_state <= S_FETCH;
                    end
                end
                S_HALTED: r_state <= S_HALTED;
                default:  r_state <= S_IDLE;
            endcase
        end
    end

`ifdef PC_RETIRE_CNT_EN
    logic [31:0] r_retireCount;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_retireCount <= 32'd0;
        end else if (r_state == S_COMMIT) begin
            r_retireCount <= r_retireCount + 32'd1;
        end
    end

    assign retire_count = r_retireCount;
`else
    assign retire_count = 32'd0;
`endif

    assign state     = r_state;
    assign pc        = r_pc;
    assign pc_update = r_pcUpdate;
    assign link_we   = r_linkWe;
    assign link_data = r_linkData;
    assign fetch_req = (r_state == S_FETCH);
    assign busy      = (r_state == S_FETCH) || (r_state == S_WAIT_DEC) ||
                       (r_state == S_RESOLVE) || (r_state == S_COMMIT);

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer; expected values are hand-computed.
// Honours PC_RETIRE_CNT_EN when predicting retire_count.
module tb_pc_sequencer;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        halt;
    logic        fetch_req;
    logic        fetch_ready;
    logic        instr_valid;
    logic [3:0]  path_index;
    logic [25:0] addr;
    logic [15:0] imm;
    logic        branch_taken;
    logic [31:0] reg_addr;
    logic [31:0] pc;
    logic        pc_update;
    logic        link_we;
    logic [31:0] link_data;
    logic        busy;
    logic [2:0]  state;
    logic [31:0] retire_count;

    int checkCount = 0;
    int passCount  = 0;
    int strayPulses = 0;
    logic [31:0] expRetire;

    pc_sequencer #(.RESET_PC(32'd0)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .halt(halt),
        .fetch_req(fetch_req), .fetch_ready(fetch_ready), .instr_valid(instr_valid),
        .path_index(path_index), .addr(addr), .imm(imm), .branch_taken(branch_taken),
        .reg_addr(reg_addr), .pc(pc), .pc_update(pc_update), .link_we(link_we),
        .link_data(link_data), .busy(busy), .state(state), .retire_count(retire_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulses must never be seen outside COMMIT.
    always @(negedge clk) begin
        if ((pc_update || link_we) && state != 3'd4) strayPulses++;
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual === expected) passCount++;
        else $display("[TB] FAIL %s actual=0x%08h expected=0x%08h", tag, actual, expected);
    endtask

    task automatic resetDut();
        rst_n = 1'b0;
        start = 1'b0;
        halt  = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic startRun(input string tag);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        halt  = 1'b0;
        checkOutput({tag, "_state"}, {29'd0, state}, 32'd1);
    endtask

    // Entered at a negedge in FETCH; runs one instruction and checks the commit and the new PC.
    task automatic applyStimulus(input string tag, input logic [3:0] p, input logic [25:0] a,
                                 input logic [15:0] im, input logic tk, input logic [31:0] ra,
                                 input logic [31:0] expPc, input logic expLink,
                                 input logic [31:0] expLinkData);
        int waited;
        path_index   = p;
        addr         = a;
        imm          = im;
        branch_taken = tk;
        reg_addr     = ra;
        waited = 0;
        while (state != 3'd4 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        checkOutput({tag, "_latency"}, waited, 32'd3);
        checkOutput({tag, "_pc_update"}, {31'd0, pc_update}, 32'd1);
        checkOutput({tag, "_link_we"}, {31'd0, link_we}, {31'd0, expLink});
        if (expLink) checkOutput({tag, "_link_data"}, link_data, expLinkData);
        @(negedge clk);
        checkOutput({tag, "_pc"}, pc, expPc);
        checkOutput({tag, "_state"}, {29'd0, state}, 32'd1);
        checkOutput({tag, "_pulse_drop"}, {31'd0, pc_update}, 32'd0);
    endtask

    initial begin
        fetch_ready  = 1'b1;
        instr_valid  = 1'b1;
        path_index   = 4'd0;
        addr         = 26'd0;
        imm          = 16'd0;
        branch_taken = 1'b0;
        reg_addr     = 32'd0;
        resetDut();

        $display("[TB] reset state");
        checkOutput("rst_state", {29'd0, state}, 32'd0);
        checkOutput("rst_pc", pc, 32'd0);
        checkOutput("rst_fetch_req", {31'd0, fetch_req}, 32'd0);
        checkOutput("rst_busy", {31'd0, busy}, 32'd0);
        checkOutput("rst_pc_update", {31'd0, pc_update}, 32'd0);
        checkOutput("rst_link_we", {31'd0, link_we}, 32'd0);
        checkOutput("rst_link_data", link_data, 32'd0);
        checkOutput("rst_retire", retire_count, 32'd0);

        $display("[TB] idle hold, then sequential run");
        @(negedge clk);
        checkOutput("idle_hold", {29'd0, state}, 32'd0);
        startRun("start");
        checkOutput("fetch_req", {31'd0, fetch_req}, 32'd1);
        checkOutput("fetch_busy", {31'd0, busy}, 32'd1);
        applyStimulus("seq1", 4'd0, 26'd0, 16'd0, 1'b0, 32'd0, 32'd1, 1'b0, 32'd0);
        applyStimulus("seq2", 4'd0, 26'd0, 16'd0, 1'b0, 32'd0, 32'd2, 1'b0, 32'd0);
        applyStimulus("seq3", 4'd0, 26'd0, 16'd0, 1'b0, 32'd0, 32'd3, 1'b0, 32'd0);
`ifdef PC_RETIRE_CNT_EN
        expRetire = 32'd3;
`else
        expRetire = 32'd0;
`endif
        checkOutput("retire_after3", retire_count, expRetire);

        $display("[TB] jumps");
        applyStimulus("jr10", 4'd8, 26'd0, 16'd0, 1'b0, 32'h10, 32'h10, 1'b0, 32'd0);
        applyStimulus("jal", 4'd6, 26'h123, 16'd0, 1'b0, 32'd0, 32'h123, 1'b1, 32'h11);
        applyStimulus("jr10b", 4'd8, 26'd0, 16'd0, 1'b0, 32'h10, 32'h10, 1'b0, 32'd0);
        applyStimulus("j", 4'd5, 26'h123, 16'd0, 1'b0, 32'd0, 32'h123, 1'b0, 32'd0);
        applyStimulus("jr_hi", 4'd8, 26'd0, 16'd0, 1'b0, 32'hFC00_0005, 32'hFC00_0005, 1'b0, 32'd0);
        applyStimulus("j_hi", 4'd5, 26'h3, 16'd0, 1'b0, 32'd0, 32'hFC00_0003, 1'b0, 32'd0);

        $display("[TB] branches");
        applyStimulus("jr20", 4'd8, 26'd0, 16'd0, 1'b0, 32'h20, 32'h20, 1'b0, 32'd0);
        applyStimulus("br_taken", 4'd4, 26'd0, 16'hFFFC, 1'b1, 32'd0, 32'h1D, 1'b0, 32'd0);
        applyStimulus("jr20b", 4'd8, 26'd0, 16'd0, 1'b0, 32'h20, 32'h20, 1'b0, 32'd0);
        applyStimulus("br_not", 4'd4, 26'd0, 16'hFFFC, 1'b0, 32'd0, 32'h21, 1'b0, 32'd0);
        applyStimulus("other_code", 4'd7, 26'h3FF, 16'h0005, 1'b1, 32'h99, 32'h22, 1'b0, 32'd0);

        $display("[TB] wrap");
        applyStimulus("jr_max", 4'd8, 26'd0, 16'd0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'd0);
        applyStimulus("wrap", 4'd0, 26'd0, 16'd0, 1'b0, 32'd0, 32'h0, 1'b0, 32'd0);

        $display("[TB] fetch stall");
        fetch_ready = 1'b0;
        path_index  = 4'd0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput("stall_state", {29'd0, state}, 32'd1);
            checkOutput("stall_fetch_req", {31'd0, fetch_req}, 32'd1);
            checkOutput("stall_pc", pc, 32'd0);
        end
        fetch_ready = 1'b1;
        applyStimulus("after_stall", 4'd0, 26'd0, 16'd0, 1'b0, 32'd0, 32'd1, 1'b0, 32'd0);

        $display("[TB] halt during WAIT_DEC");
        path_index = 4'd0;
        @(negedge clk);
        checkOutput("hw_wait_dec", {29'd0, state}, 32'd2);
        halt = 1'b1;
        @(negedge clk);
        halt = 1'b0;
        @(negedge clk);
        checkOutput("hw_commit", {29'd0, state}, 32'd4);
        checkOutput("hw_pc_update", {31'd0, pc_update}, 32'd1);
        @(negedge clk);
        checkOutput("hw_halted", {29'd0, state}, 32'd5);
        checkOutput("hw_busy", {31'd0, busy}, 32'd0);
        checkOutput("hw_fetch_req", {31'd0, fetch_req}, 32'd0);
        checkOutput("hw_pc", pc, 32'd2);
        start = 1'b1;
        repeat (3) @(negedge clk);
        start = 1'b0;
        checkOutput("hw_stays", {29'd0, state}, 32'd5);

        $display("[TB] start and halt together in IDLE");
        resetDut();
        halt = 1'b1;
        startRun("sh");
        applyStimulus("sh_noHalt", 4'd0, 26'd0, 16'd0, 1'b0, 32'd0, 32'd1, 1'b0, 32'd0);

        $display("[TB] halt during COMMIT");
        repeat (3) @(negedge clk);
        checkOutput("hc_commit", {29'd0, state}, 32'd4);
        halt = 1'b1;
        @(negedge clk);
        halt = 1'b0;
        checkOutput("hc_halted", {29'd0, state}, 32'd5);
        checkOutput("hc_pc", pc, 32'd2);

        $display("[TB] reset in RESOLVE");
        resetDut();
        startRun("rr");
        applyStimulus("rr_jr", 4'd8, 26'd0, 16'd0, 1'b0, 32'h55, 32'h55, 1'b0, 32'd0);
        path_index = 4'd6;
        repeat (2) @(negedge clk);
        checkOutput("rr_resolve", {29'd0, state}, 32'd3);
        rst_n = 1'b0;
        @(negedge clk);
        checkOutput("rr_state", {29'd0, state}, 32'd0);
        checkOutput("rr_pc", pc, 32'd0);
        checkOutput("rr_pc_update", {31'd0, pc_update}, 32'd0);
        checkOutput("rr_link_we", {31'd0, link_we}, 32'd0);
        checkOutput("rr_retire", retire_count, 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("rr_idle", {29'd0, state}, 32'd0);
        checkOutput("stray_pulses", strayPulses, 32'd0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
